// File: rtl/uart_frame_tx.sv
// RFC1662-style framer feeding a byte-wide UART: flag, stuffed payload, stuffed FCS-16, flag.
// One frame in flight; the host is backpressured until the UART accepts each byte.
`timescale 1ns/1ps
module uart_frame_tx #(
    parameter bit FCS_EN      = 1'b1,
    parameter bit ESCAPE_CTRL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_strobe,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SOF, PAYLOAD, FCS0, FCS1, EOF} state_t;

    localparam logic [7:0] FLAG = 8'h7E;
    localparam logic [7:0] ESC  = 8'h7D;

    state_t      state, state_nx;
    logic [15:0] crc, crc_nx;
    logic        esc_pend, esc_pend_nx;
    logic [7:0]  esc_byte, esc_byte_nx;
    logic        last_pend, last_pend_nx;
    logic        tx_strobe_nx;
    logic [7:0]  tx_data_nx;
    logic        emit_ok;
    logic [7:0]  fcs_byte;
    state_t      after_payload, after_fcs;

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == FLAG) || (b == ESC) || (ESCAPE_CTRL && (b < 8'h20));
    endfunction

    // CRC-16/X.25, reflected: one byte, LSB first, fully unrolled
    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // tx_ready only reflects a strobe one cycle late, so a strobe cycle is never a slot
    assign emit_ok       = tx_ready & ~tx_strobe;
    assign after_payload = FCS_EN ? FCS0 : EOF;
    assign after_fcs     = (state == FCS0) ? FCS1 : EOF;
    assign fcs_byte      = (state == FCS0) ? ~crc[7:0] : ~crc[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            crc       <= 16'hFFFF;
            esc_pend  <= 1'b0;
            esc_byte  <= 8'h00;
            last_pend <= 1'b0;
            tx_strobe <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            state     <= state_nx;
            crc       <= crc_nx;
            esc_pend  <= esc_pend_nx;
            esc_byte  <= esc_byte_nx;
            last_pend <= last_pend_nx;
            tx_strobe <= tx_strobe_nx;
            tx_data   <= tx_data_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        crc_nx       = crc;
        esc_pend_nx  = esc_pend;
        esc_byte_nx  = esc_byte;
        last_pend_nx = last_pend;
        tx_strobe_nx = 1'b0;
        tx_data_nx   = tx_data;
        if (state == IDLE) begin
            if (in_valid) begin
                state_nx = SOF;
                crc_nx   = 16'hFFFF;
            end
        end else if (emit_ok) begin
            if (esc_pend) begin
                // second half of an escape pair; the deferred state advance happens here
                tx_strobe_nx = 1'b1;
                tx_data_nx   = esc_byte;
                esc_pend_nx  = 1'b0;
                case (state)
                    PAYLOAD: if (last_pend) begin
                        state_nx     = after_payload;
                        last_pend_nx = 1'b0;
                    end
                    FCS0:    state_nx = FCS1;
                    FCS1:    state_nx = EOF;
                    default: ;
                endcase
            end else begin
                case (state)
                    SOF: begin
                        tx_strobe_nx = 1'b1;
                        tx_data_nx   = FLAG;
                        state_nx     = PAYLOAD;
                    end
                    PAYLOAD: if (in_valid) begin
                        crc_nx       = crc_byte(crc, in_data);
                        tx_strobe_nx = 1'b1;
                        if (needs_esc(in_data)) begin
                            tx_data_nx   = ESC;
                            esc_pend_nx  = 1'b1;
                            esc_byte_nx  = in_data ^ 8'h20;
                            last_pend_nx = in_last;
                        end else begin
                            tx_data_nx = in_data;
                            if (in_last) state_nx = after_payload;
                        end
                    end
                    FCS0, FCS1: begin
                        tx_strobe_nx = 1'b1;
                        if (needs_esc(fcs_byte)) begin
                            tx_data_nx  = ESC;
                            esc_pend_nx = 1'b1;
                            esc_byte_nx = fcs_byte ^ 8'h20;
                        end else begin
                            tx_data_nx = fcs_byte;
                            state_nx   = after_fcs;
                        end
                    end
                    EOF: begin
                        tx_strobe_nx = 1'b1;
                        tx_data_nx   = FLAG;
                        state_nx     = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        in_ready = (state == PAYLOAD) & emit_ok & ~esc_pend;
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three parameterisations share stimulus, a scoreboard
// queue holds expected UART bytes and a negedge monitor pops/compares every strobe.
`timescale 1ns/1ps
module tb_uart_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       tx_ready;
    int         sel = 0;

    logic       in_ready_w [3];
    logic       tx_strobe_w[3];
    logic       busy_w     [3];
    logic [7:0] tx_data_w  [3];

    logic [7:0] q[$];
    logic [7:0] pkt[$];
    int         n_asrt = 0;
    int         n_fail = 0;
    logic       prev_strobe = 1'b0;
    int         byte_time = 0;
    bit         hold_ok = 1'b1;
    int         bcnt = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.FCS_EN(1'b1), .ESCAPE_CTRL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 0),
        .in_last(in_last), .in_ready(in_ready_w[0]), .tx_data(tx_data_w[0]),
        .tx_strobe(tx_strobe_w[0]), .tx_ready(tx_ready), .busy(busy_w[0]));
    uart_frame_tx #(.FCS_EN(1'b0), .ESCAPE_CTRL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 1),
        .in_last(in_last), .in_ready(in_ready_w[1]), .tx_data(tx_data_w[1]),
        .tx_strobe(tx_strobe_w[1]), .tx_ready(tx_ready), .busy(busy_w[1]));
    uart_frame_tx #(.FCS_EN(1'b0), .ESCAPE_CTRL(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 2),
        .in_last(in_last), .in_ready(in_ready_w[2]), .tx_data(tx_data_w[2]),
        .tx_strobe(tx_strobe_w[2]), .tx_ready(tx_ready), .busy(busy_w[2]));

    // UART stand-in: busy for byte_time cycles after seeing a strobe
    assign tx_ready = hold_ok && (bcnt == 0);
    always @(posedge clk) begin
        if (tx_strobe_w[sel]) bcnt <= byte_time;
        else if (bcnt > 0)    bcnt <= bcnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_strobe_w[sel]) begin
                check("no_adjacent_strobe", {31'd0, prev_strobe}, 32'd0);
                n_asrt++;
                assert (q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_byte: observed %0h expected no byte", tx_data_w[sel]);
                end
                if (q.size() != 0) check("tx_byte", {24'd0, tx_data_w[sel]}, {24'd0, q.pop_front()});
            end
            if (in_ready_w[sel])
                check("in_ready_slot", {30'd0, tx_strobe_w[sel], tx_ready}, 32'd1);
        end
        prev_strobe <= tx_strobe_w[sel];
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[j];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'h8408;
        end
        return c;
    endfunction

    task automatic push_esc(input logic [7:0] b, input bit esc_ctrl);
        if (b == 8'h7E || b == 8'h7D || (esc_ctrl && b < 8'h20)) begin
            q.push_back(8'h7D);
            q.push_back(b ^ 8'h20);
        end else q.push_back(b);
    endtask

    task automatic push_frame(input bit fcs_en, input bit esc_ctrl);
        logic [15:0] c;
        c = 16'hFFFF;
        q.push_back(8'h7E);
        foreach (pkt[i]) begin
            push_esc(pkt[i], esc_ctrl);
            c = crc_upd(c, pkt[i]);
        end
        c = c ^ 16'hFFFF;
        if (fcs_en) begin
            push_esc(c[7:0], esc_ctrl);
            push_esc(c[15:8], esc_ctrl);
        end
        q.push_back(8'h7E);
    endtask

    task automatic push_list(input logic [7:0] l[$]);
        foreach (l[i]) q.push_back(l[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int cnt;
        cnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready_w[sel] && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("in_ready_timeout", {31'd0, cnt < 2000}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_pkt(input bit keep_valid);
        foreach (pkt[i]) send_byte(pkt[i], i == pkt.size() - 1);
        if (!keep_valid) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while ((q.size() != 0 || busy_w[sel]) && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("frame_done_timeout", {31'd0, cnt < 5000}, 32'd1);
        check("queue_drained", q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] ref1[$] = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                            8'h37, 8'h38, 8'h39, 8'h6E, 8'h90, 8'h7E};
    logic [7:0] held;

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_strobe", {31'd0, tx_strobe_w[0]}, 32'd0);
        check("rst_data",   {24'd0, tx_data_w[0]}, 32'd0);
        check("rst_ready",  {31'd0, in_ready_w[0]}, 32'd0);
        check("rst_busy",   {29'd0, busy_w[0], busy_w[1], busy_w[2]}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reference CRC vector
        sel = 0; byte_time = 0;
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_list(ref1);
        send_pkt(1'b0);
        wait_done();

        // 2: flag/escape stuffing, no FCS
        sel = 2; byte_time = 2;
        pkt = '{8'h7E, 8'h7D, 8'h11};
        push_list('{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h11, 8'h7E});
        send_pkt(1'b0);
        wait_done();

        // 3: control-character escaping on and off
        sel = 1;
        pkt = '{8'h03, 8'h20};
        push_list('{8'h7E, 8'h7D, 8'h23, 8'h20, 8'h7E});
        send_pkt(1'b0);
        wait_done();
        sel = 2;
        push_list('{8'h7E, 8'h03, 8'h20, 8'h7E});
        send_pkt(1'b0);
        wait_done();

        // 4: UART stalls mid-frame
        sel = 0; byte_time = 3;
        pkt = '{8'hA0, 8'h7D, 8'h5A, 8'h7E, 8'h00, 8'hFF, 8'h12, 8'h34};
        push_frame(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(pkt[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        hold_ok  = 1'b0;
        @(negedge clk);
        held = tx_data_w[0];
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 0) begin
                check("stall_strobe", {31'd0, tx_strobe_w[0]}, 32'd0);
                check("stall_data",   {24'd0, tx_data_w[0]}, {24'd0, held});
                check("stall_ready",  {31'd0, in_ready_w[0]}, 32'd0);
            end
        end
        hold_ok = 1'b1;
        for (int i = 4; i < pkt.size(); i++) send_byte(pkt[i], i == pkt.size() - 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_done();

        // 5: async reset mid-payload, then a clean frame
        byte_time = 0;
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(pkt[i], 1'b0);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_strobe", {31'd0, tx_strobe_w[0]}, 32'd0);
        check("arst_ready",  {31'd0, in_ready_w[0]}, 32'd0);
        check("arst_busy",   {31'd0, busy_w[0]}, 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_list(ref1);
        send_pkt(1'b0);
        wait_done();

        // 6: back-to-back packets with in_valid never dropping
        byte_time = 4;
        pkt = '{8'h7E, 8'h01, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        push_frame(1'b1, 1'b0);
        send_pkt(1'b1);
        pkt = '{8'($urandom_range(0, 255)), 8'h7D, 8'($urandom_range(0, 255))};
        push_frame(1'b1, 1'b0);
        send_pkt(1'b0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
